// File: rtl/layer_header_fetch.sv
// layer_header_fetch: on frame_start, reads each layer's header words from
// the layer register memory, packs them into one wide packet and emits it
// with a valid/ready handshake. The last layer is followed by a frame_done pulse.
// Optional feature macro: LAYER_SKIP_DISABLED_EN. When it is defined, a layer
// whose captured word 0 bit 0 is clear is skipped without being emitted.
module layer_header_fetch #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned NUM_LAYERS      = 8,
    parameter int unsigned WORDS_PER_LAYER = 4,
    localparam int unsigned ADDR_W  = (NUM_LAYERS * WORDS_PER_LAYER > 1) ?
                                      $clog2(NUM_LAYERS * WORDS_PER_LAYER) : 1,
    localparam int unsigned LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  frame_start,
    output logic [ADDR_W-1:0]                     rd_addr,
    input  logic [DATA_WIDTH-1:0]                 rd_data,
    output logic                                  hdr_valid,
    input  logic                                  hdr_ready,
    output logic [DATA_WIDTH*WORDS_PER_LAYER-1:0] hdr_data,
    output logic [LAYER_W-1:0]                    hdr_layer,
    output logic                                  busy,
    output logic                                  frame_done
);

    localparam int unsigned WORD_W = (WORDS_PER_LAYER > 1) ? $clog2(WORDS_PER_LAYER) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t              state;
    logic [LAYER_W-1:0]  layer;
    logic [WORD_W-1:0]   word;
    logic                last_word_c;
    logic                last_layer_c;
    logic                keep_c;

    assign last_word_c  = (word  == WORD_W'(WORDS_PER_LAYER - 1));
    assign last_layer_c = (layer == LAYER_W'(NUM_LAYERS - 1));

    // Layer enable is word 0 bit 0; with a single word per layer it is still on rd_data.
`ifdef LAYER_SKIP_DISABLED_EN
    assign keep_c = (word == '0) ? rd_data[0] : hdr_data[0];
`else
    assign keep_c = 1'b1;
`endif

    // Memory address is only driven while reading; parked at zero otherwise.
    assign rd_addr = (state == READ) ?
                     ADDR_W'(ADDR_W'(layer) * ADDR_W'(WORDS_PER_LAYER) + ADDR_W'(word)) :
                     '0;

    assign hdr_layer = layer;
    assign busy      = (state != IDLE);

    // Scan sequencer: read words, present packet, advance layer, close frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            layer      <= '0;
            word       <= '0;
            hdr_data   <= '0;
            hdr_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        layer <= '0;
                        word  <= '0;
                        state <= READ;
                    end
                end
                READ: begin
                    for (int k = 0; k < WORDS_PER_LAYER; k++) begin
                        if (word == WORD_W'(k)) begin
                            hdr_data[k*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
                        end
                    end
                    if (last_word_c) begin
                        word <= '0;
                        if (keep_c) begin
                            state <= EMIT;
                        end else if (last_layer_c) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            layer <= layer + 1'b1;
                            state <= READ;
                        end
                    end else begin
                        word <= word + 1'b1;
                    end
                end
                EMIT: begin
                    // Packet is presented on the cycle after READ exit.
                    if (!hdr_valid) begin
                        hdr_valid <= 1'b1;
                    end else if (hdr_ready) begin
                        hdr_valid <= 1'b0;
                        word      <= '0;
                        if (last_layer_c) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            layer <= layer + 1'b1;
                            state <= READ;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    hdr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/layer_header_fetch.md
LAYER_HEADER_FETCH -- requirements
Module: layer_header_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one layer register word.
REQ-002 Parameter NUM_LAYERS, default 8, number of layers scanned per frame.
REQ-003 Parameter WORDS_PER_LAYER, default 4, register words per layer header; ADDR_W = ceil(log2(NUM_LAYERS*WORDS_PER_LAYER)), LAYER_W = ceil(log2(NUM_LAYERS)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 frame_start  input  1  one-cycle request to scan all layer headers.
REQ-007 rd_addr  output  ADDR_W  read address to layer register memory read port.
REQ-008 rd_data  input  DATA_WIDTH  asynchronous read data returned for rd_addr in the same cycle.
REQ-009 hdr_valid  output  1  header packet valid.
REQ-010 hdr_ready  input  1  downstream accepts packet.
REQ-011 hdr_data  output  DATA_WIDTH*WORDS_PER_LAYER  assembled header; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 hdr_layer  output  LAYER_W  layer index of hdr_data.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_done  output  1  one-cycle pulse when the scan finishes.

Function
REQ-015 FSM states SHALL be IDLE, READ, EMIT; layer counter and word counter SHALL be registered.
REQ-016 IDLE: frame_start high at an edge SHALL load layer=0, word=0, state=READ; otherwise stay in IDLE.
REQ-017 rd_addr SHALL equal layer*WORDS_PER_LAYER+word combinationally in READ, and 0 in IDLE and EMIT.
REQ-018 READ: each edge SHALL capture rd_data into header word [word] and increment word; the edge capturing word WORDS_PER_LAYER-1 SHALL exit READ.
REQ-019 On READ exit, a kept layer SHALL go to EMIT with hdr_valid=1 on the following cycle; hdr_valid SHALL rise 5 edges after the edge sampling frame_start (default parameters).
REQ-020 EMIT: hdr_data and hdr_layer SHALL hold stable while hdr_valid=1 and hdr_ready=0.
REQ-021 Transfer SHALL occur at an edge with hdr_valid=1 and hdr_ready=1; hdr_valid SHALL deassert after the transfer.
REQ-022 After a transfer (or a skip, REQ-029) on layer < NUM_LAYERS-1: layer+1, word=0, state=READ.
REQ-023 After the transfer or skip of layer NUM_LAYERS-1: state=IDLE, frame_done=1 for exactly one cycle.
REQ-024 frame_start while busy=1 SHALL be ignored; no queuing.
REQ-025 hdr_ready while hdr_valid=0 SHALL have no effect.
REQ-026 Counters SHALL never exceed NUM_LAYERS-1 / WORDS_PER_LAYER-1; no wrap-around past the last layer.

Reset
REQ-027 rst_n low at an edge SHALL force state=IDLE, layer=0, word=0, header words=0, hdr_valid=0, frame_done=0, busy=0, hdr_layer=0, rd_addr=0, including mid-READ or mid-EMIT; no packet or frame_done SHALL be produced for the aborted frame.
REQ-028 frame_start sampled in the same edge as rst_n=0 SHALL be ignored.

Configuration
REQ-029 Macro LAYER_SKIP_DISABLED_EN defined: layer whose captured word 0 bit 0 (layer enable) is 0 SHALL be skipped at READ exit, no EMIT, hdr_valid stays 0.
REQ-030 Macro undefined: every layer SHALL be emitted regardless of word 0 bit 0; bit passed through unchanged in hdr_data.

Verification
REQ-031 Memory word n = n, hdr_ready=1, pulse frame_start -> 8 packets, layer 0 hdr_data=0x0003_0002_0001_0000, layer 7 =0x001F_001E_001D_001C, frame_done one pulse after layer 7 transfer.
REQ-032 hdr_ready=0 for 10 cycles on layer 2 -> hdr_valid high, hdr_data/hdr_layer=2 constant all 10 cycles, single transfer after ready rises.
REQ-033 LAYER_SKIP_DISABLED_EN defined, only layers 1 and 5 have word0 bit0=1 -> exactly 2 packets, hdr_layer 1 then 5, then frame_done; all layers disabled -> 0 packets, frame_done still pulses.
REQ-034 frame_start pulsed again during layer 3 READ -> ignored, exactly 8 packets, one frame_done.
REQ-035 rst_n low for 1 cycle during layer 4 EMIT -> next cycle hdr_valid=0, busy=0, rd_addr=0, no frame_done; new frame_start restarts at layer 0.
